// File: rtl/sys_ctrl_pkg.sv
// Shared types and default sizing for the systolic array controller.
package sys_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFeed,
    StDrain,
    StDone
  } ctrl_state_e;

  localparam int unsigned DefSysDim  = 32;
  localparam int unsigned DefFeatLen = 128;
  localparam int unsigned DefRdLat   = 1;
  localparam int unsigned DefPipeLat = 2 * DefSysDim;

endpackage

// File: rtl/sys_array_ctrl.sv
// Job sequencer for a systolic array: streams N operand reads, then waits for the
// N result rows to emerge from the array pipeline. All outputs are registered.
module sys_array_ctrl
  import sys_ctrl_pkg::*;
#(
  parameter int unsigned SYS_DIM  = DefSysDim,
  parameter int unsigned FEAT_LEN = DefFeatLen,
  parameter int unsigned RD_LAT   = DefRdLat,
  parameter int unsigned PIPE_LAT = 2 * SYS_DIM,
  localparam int unsigned AW      = $clog2(FEAT_LEN) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] num_steps,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic          array_en,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  output logic          out_valid,
  output logic [AW-1:0] out_addr
);

  localparam int unsigned Lat = RD_LAT + PIPE_LAT;
  // Elapsed counter must reach N + Lat without wrapping.
  localparam int unsigned CW  = $clog2(FEAT_LEN + Lat + 1) + 1;
  localparam logic [CW-1:0] LatC     = CW'(Lat);
  localparam logic [AW-1:0] FeatLenC = AW'(FEAT_LEN);

  ctrl_state_e   state_q, state_d;
  logic [AW-1:0] n_q, n_d;
  logic [AW-1:0] step_q, step_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          array_en_q, array_en_d;
  logic          rd_en_q, rd_en_d;
  logic          out_valid_q, out_valid_d;
  logic [AW-1:0] out_addr_q, out_addr_d;
  logic          run;

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    step_d  = step_q;
    cyc_d   = cyc_q;

    case (state_q)
      StIdle: begin
        if (start && !abort) begin
          if (num_steps == '0) begin
            state_d = StDone;
          end else begin
            state_d = StFeed;
            n_d     = (num_steps > FeatLenC) ? FeatLenC : num_steps;
            step_d  = '0;
            cyc_d   = '0;
          end
        end
      end
      StFeed: begin
        if (abort) begin
          state_d = StIdle;
          n_d     = '0;
          step_d  = '0;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_q + CW'(1);
          if (step_q == n_q - AW'(1)) begin
            state_d = StDrain;
            step_d  = '0;
          end else begin
            step_d = step_q + AW'(1);
          end
        end
      end
      StDrain: begin
        if (abort || (out_valid_q && out_addr_q == n_q - AW'(1))) begin
          state_d = abort ? StIdle : StDone;
          n_d     = '0;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Outputs are decoded from the next state so they land in the same cycle as it.
    run         = (state_d == StFeed) || (state_d == StDrain);
    busy_d      = run;
    array_en_d  = run;
    done_d      = (state_d == StDone);
    rd_en_d     = (state_d == StFeed);
    out_valid_d = run && (cyc_d >= LatC) && (cyc_d < LatC + CW'(n_d));
    out_addr_d  = out_valid_d ? AW'(cyc_d - LatC) : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      n_q         <= '0;
      step_q      <= '0;
      cyc_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      array_en_q  <= 1'b0;
      rd_en_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      step_q      <= step_d;
      cyc_q       <= cyc_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      array_en_q  <= array_en_d;
      rd_en_q     <= rd_en_d;
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign array_en  = array_en_q;
  assign rd_en     = rd_en_q;
  assign rd_addr   = step_q;
  assign out_valid = out_valid_q;
  assign out_addr  = out_addr_q;

endmodule

// File: tb/tb_sys_array_ctrl.sv
// Bench for sys_array_ctrl: a job-level timing model checked every cycle, plus
// literal expectations for the directed scenarios.
module tb_sys_array_ctrl;

  localparam int AW = 8;
  localparam int L  = 9;  // RD_LAT + PIPE_LAT

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] num_steps = '0;
  logic          abort = 1'b0;
  logic          busy, done, array_en, rd_en, out_valid;
  logic [AW-1:0] rd_addr, out_addr;

  int total = 0;
  int bad   = 0;

  sys_array_ctrl #(
    .SYS_DIM (4),
    .FEAT_LEN(128),
    .RD_LAT  (1),
    .PIPE_LAT(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .num_steps(num_steps),
    .abort    (abort),
    .busy     (busy),
    .done     (done),
    .array_en (array_en),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .out_valid(out_valid),
    .out_addr (out_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Job model: a job is its accept edge, its clamped length and whether it is still live.
  // kc is the job-relative cycle number, 1 being the cycle after the accepting edge.
  bit j_on;
  int j_p, j_n, pe, kc;
  assign kc = pe - j_p + 1;

  function automatic int done_k(input int n);
    return (n == 0) ? 1 : n + L + 1;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      j_on <= 1'b0;
      pe   <= 0;
      j_p  <= 0;
      j_n  <= 0;
    end else begin
      pe <= pe + 1;
      if (j_on && (kc == done_k(j_n) || abort)) j_on <= 1'b0;
      if (!j_on && start && !abort) begin
        j_on <= 1'b1;
        j_p  <= pe + 1;
        j_n  <= (int'(num_steps) > 128) ? 128 : int'(num_steps);
      end
    end
  end

  bit e_busy, e_rd, e_ov, e_done;
  int e_ra, e_oa;
  always_comb begin
    e_busy = 1'b0;
    e_rd   = 1'b0;
    e_ov   = 1'b0;
    e_done = 1'b0;
    e_ra   = 0;
    e_oa   = 0;
    if (j_on) begin
      if (j_n == 0) begin
        e_done = (kc == 1);
      end else begin
        e_rd   = (kc <= j_n);
        e_ra   = kc - 1;
        e_busy = (kc <= j_n + L);
        e_ov   = (kc > L) && (kc <= L + j_n);
        e_oa   = kc - 1 - L;
        e_done = (kc == j_n + L + 1);
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("busy", int'(busy), int'(e_busy));
      chk("array_en", int'(array_en), int'(e_busy));
      chk("rd_en", int'(rd_en), int'(e_rd));
      chk("out_valid", int'(out_valid), int'(e_ov));
      chk("done", int'(done), int'(e_done));
      if (e_rd) chk("rd_addr", int'(rd_addr), e_ra);
      if (e_ov) chk("out_addr", int'(out_addr), e_oa);
    end
  end

  // Per-job observations, cycle numbers relative to the start edge.
  int rd_cnt, rd_first, rd_last, ov_cnt, ov_first, ov_last, ov_last_addr;
  int done_cnt, done_cyc, busy_first, busy_last, ae_cnt;

  // Called at a negedge; start is sampled on the following edge (edge 0).
  task automatic run_job(input int n, input int s2, input int ab, input int ncyc);
    rd_cnt = 0; rd_first = -1; rd_last = -1;
    ov_cnt = 0; ov_first = -1; ov_last = -1; ov_last_addr = -1;
    done_cnt = 0; done_cyc = -1; busy_first = -1; busy_last = -1; ae_cnt = 0;
    start = 1'b1;
    num_steps = AW'(n);
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      start = (c == s2);
      abort = (c == ab);
      if (rd_en) begin
        rd_cnt++;
        if (rd_first < 0) rd_first = c;
        rd_last = c;
      end
      if (out_valid) begin
        ov_cnt++;
        if (ov_first < 0) ov_first = c;
        ov_last = c;
        ov_last_addr = int'(out_addr);
      end
      if (done) begin
        done_cnt++;
        done_cyc = c;
      end
      if (busy) begin
        if (busy_first < 0) busy_first = c;
        busy_last = c;
      end
      if (array_en) ae_cnt++;
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " busy"}, int'(busy), 0);
    chk({tag, " done"}, int'(done), 0);
    chk({tag, " array_en"}, int'(array_en), 0);
    chk({tag, " rd_en"}, int'(rd_en), 0);
    chk({tag, " rd_addr"}, int'(rd_addr), 0);
    chk({tag, " out_valid"}, int'(out_valid), 0);
    chk({tag, " out_addr"}, int'(out_addr), 0);
  endtask

  task automatic chk_n3(input string tag);
    chk({tag, " rd_first"}, rd_first, 1);
    chk({tag, " rd_last"}, rd_last, 3);
    chk({tag, " ov_first"}, ov_first, 10);
    chk({tag, " ov_last"}, ov_last, 12);
    chk({tag, " ov_last_addr"}, ov_last_addr, 2);
    chk({tag, " done_cyc"}, done_cyc, 13);
    chk({tag, " done_cnt"}, done_cnt, 1);
    chk({tag, " busy_first"}, busy_first, 1);
    chk({tag, " busy_last"}, busy_last, 12);
  endtask

  initial begin
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst = 1'b1;

    // First start on the first edge after release; basic N=3 job.
    run_job(3, -1, -1, 16);
    chk_n3("n3");

    // Extra start while busy is ignored.
    run_job(3, 5, -1, 16);
    chk_n3("n3_restart");

    // Abort sampled on the edge ending cycle 10: one row out, no completion.
    run_job(3, -1, 10, 16);
    chk("abort ov_cnt", ov_cnt, 1);
    chk("abort ov_first", ov_first, 10);
    chk("abort done_cnt", done_cnt, 0);
    chk("abort busy_last", busy_last, 10);
    chk_zero("abort idle");

    // Zero-length job completes straight away.
    run_job(0, -1, -1, 4);
    chk("n0 done_cyc", done_cyc, 1);
    chk("n0 done_cnt", done_cnt, 1);
    chk("n0 rd_cnt", rd_cnt, 0);
    chk("n0 ae_cnt", ae_cnt, 0);
    chk("n0 ov_cnt", ov_cnt, 0);

    // Oversized request is clamped to FEAT_LEN.
    run_job(200, -1, -1, 142);
    chk("clamp rd_cnt", rd_cnt, 128);
    chk("clamp ov_cnt", ov_cnt, 128);
    chk("clamp ov_last_addr", ov_last_addr, 127);
    chk("clamp done_cyc", done_cyc, 138);

    // Start presented in the completion cycle is ignored.
    run_job(1, 11, -1, 16);
    chk("n1 done_cyc", done_cyc, 11);
    chk("n1 done_cnt", done_cnt, 1);
    chk("n1 rd_cnt", rd_cnt, 1);
    chk("n1 busy_last", busy_last, 10);

    // Reset mid-job: outputs drop at once, then a fresh job runs normally.
    run_job(3, -1, -1, 5);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_zero("midreset");
    @(negedge clk);
    rst = 1'b1;
    run_job(3, -1, -1, 16);
    chk_n3("after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

endmodule
